// File: rtl/lzss_match_sequencer.sv
// LZSS match sequencer: buffers words in a look-ahead, keeps a sliding
// history and scans one window offset per cycle for the longest match,
// then emits a literal or reference token on a valid/ready stream.
module lzss_match_sequencer #(
   parameter int WORD_SIZE       = 8,
   parameter int WINDOW_SIZE     = 16,
   parameter int LOOK_AHEAD_SIZE = 4,
   parameter int MIN_MATCH       = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [WORD_SIZE-1:0] in_data,
   input  logic                 in_last,
   output logic                 in_ready,
   output logic                 out_valid,
   output logic [WORD_SIZE:0]   out_data,
   output logic                 out_last,
   input  logic                 out_ready,
   output logic                 busy
);
   localparam int OFF_W = $clog2(WINDOW_SIZE);
   localparam int LEN_W = $clog2(LOOK_AHEAD_SIZE - MIN_MATCH + 1);
   localparam int CNT_W = $clog2(WINDOW_SIZE + 1);
   localparam int LAC_W = $clog2(LOOK_AHEAD_SIZE + 1);
   localparam int LAI_W = $clog2(LOOK_AHEAD_SIZE);

   typedef enum logic [1:0] {FILL = 2'd0, SEARCH = 2'd1, EMIT = 2'd2} state_t;

   state_t               state_q, state_d;
   logic [WORD_SIZE-1:0] la_q [LOOK_AHEAD_SIZE];
   logic [WORD_SIZE-1:0] la_d [LOOK_AHEAD_SIZE];
   logic [WORD_SIZE-1:0] hist_q [WINDOW_SIZE];
   logic [WORD_SIZE-1:0] hist_d [WINDOW_SIZE];
   logic [LAC_W-1:0]     la_cnt_q, la_cnt_d;
   logic [CNT_W-1:0]     hist_cnt_q, hist_cnt_d;
   logic                 last_seen_q, last_seen_d;
   logic [CNT_W-1:0]     off_q, off_d;
   logic [LAC_W-1:0]     best_len_q, best_len_d;
   logic [CNT_W-1:0]     best_off_q, best_off_d;
   logic                 out_valid_q, out_valid_d;
   logic [WORD_SIZE:0]   out_data_q, out_data_d;
   logic                 out_last_q, out_last_d;

   logic [LAC_W-1:0]     cur_len_s;
   logic [LAC_W-1:0]     cons_s;
   logic [LAC_W-1:0]     cons_next_s;
   logic [CNT_W:0]       hist_sum_s;
   logic                 in_ready_s;
   logic                 hs_s;

   // Match length of the look-ahead against history at the current offset.
   always_comb begin
      logic             run_v;
      logic [CNT_W-1:0] idx_v;
      cur_len_s = '0;
      run_v     = 1'b1;
      idx_v     = '0;
      for (int k = 0; k < LOOK_AHEAD_SIZE; k++) begin
         if (run_v && (LAC_W'(k) < la_cnt_q) && (CNT_W'(k) < off_q)) begin
            idx_v = off_q - CNT_W'(k) - CNT_W'(1);
            if (la_q[k] == hist_q[idx_v[OFF_W-1:0]]) begin
               cur_len_s = cur_len_s + LAC_W'(1);
            end else begin
               run_v = 1'b0;
            end
         end else begin
            run_v = 1'b0;
         end
      end
   end

   // Next-state logic for the FSM, buffers and the registered token.
   always_comb begin
      state_d     = state_q;
      la_d        = la_q;
      hist_d      = hist_q;
      la_cnt_d    = la_cnt_q;
      hist_cnt_d  = hist_cnt_q;
      last_seen_d = last_seen_q;
      off_d       = off_q;
      best_len_d  = best_len_q;
      best_off_d  = best_off_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      hist_sum_s  = '0;
      cons_next_s = LAC_W'(1);

      in_ready_s = !rst && (state_q == FILL) &&
                   (la_cnt_q < LAC_W'(LOOK_AHEAD_SIZE)) && !last_seen_q;
      hs_s       = out_valid_q && out_ready;
      cons_s     = (best_len_q >= LAC_W'(MIN_MATCH)) ? best_len_q : LAC_W'(1);

      case (state_q)
         FILL: begin
            best_len_d = '0;
            best_off_d = '0;
            if (in_valid && in_ready_s) begin
               la_d[la_cnt_q[LAI_W-1:0]] = in_data;
               la_cnt_d = la_cnt_q + LAC_W'(1);
               if (in_last) begin
                  last_seen_d = 1'b1;
               end else begin
                  last_seen_d = last_seen_q;
               end
            end else begin
               la_cnt_d = la_cnt_q;
            end
            if ((la_cnt_q == LAC_W'(LOOK_AHEAD_SIZE)) ||
                (last_seen_q && (la_cnt_q != '0))) begin
               if (hist_cnt_q != '0) begin
                  state_d = SEARCH;
                  off_d   = CNT_W'(1);
               end else begin
                  state_d = EMIT;
               end
            end else begin
               state_d = FILL;
            end
         end
         SEARCH: begin
            if (cur_len_s > best_len_q) begin
               best_len_d = cur_len_s;
               best_off_d = off_q;
            end else begin
               best_len_d = best_len_q;
            end
            if (off_q == hist_cnt_q) begin
               state_d = EMIT;
            end else begin
               off_d = off_q + CNT_W'(1);
            end
         end
         EMIT: begin
            if (hs_s) begin
               for (int i = 0; i < WINDOW_SIZE; i++) begin
                  if (i < int'(cons_s)) begin
                     hist_d[i] = la_q[LAI_W'(int'(cons_s) - 1 - i)];
                  end else begin
                     hist_d[i] = hist_q[OFF_W'(i - int'(cons_s))];
                  end
               end
               for (int i = 0; i < LOOK_AHEAD_SIZE; i++) begin
                  if (i + int'(cons_s) < LOOK_AHEAD_SIZE) begin
                     la_d[i] = la_q[LAI_W'(i + int'(cons_s))];
                  end else begin
                     la_d[i] = '0;
                  end
               end
               la_cnt_d   = la_cnt_q - cons_s;
               hist_sum_s = {1'b0, hist_cnt_q} + (CNT_W+1)'(cons_s);
               if (hist_sum_s > (CNT_W+1)'(WINDOW_SIZE)) begin
                  hist_cnt_d = CNT_W'(WINDOW_SIZE);
               end else begin
                  hist_cnt_d = hist_sum_s[CNT_W-1:0];
               end
               best_len_d  = '0;
               best_off_d  = '0;
               out_valid_d = 1'b0;
               if (out_last_q) begin
                  // Frame boundary: the next frame starts with no history.
                  hist_cnt_d  = '0;
                  la_cnt_d    = '0;
                  last_seen_d = 1'b0;
                  state_d     = FILL;
               end else if (last_seen_q) begin
                  if (hist_cnt_d != '0) begin
                     state_d = SEARCH;
                     off_d   = CNT_W'(1);
                  end else begin
                     state_d = EMIT;
                  end
               end else begin
                  state_d = FILL;
               end
            end else begin
               state_d = EMIT;
            end
         end
         default: begin
            state_d = FILL;
         end
      endcase

      // Build the token from the values the EMIT state will see.
      if ((state_d == EMIT) && ((state_q != EMIT) || hs_s)) begin
         out_valid_d = 1'b1;
         if (best_len_d >= LAC_W'(MIN_MATCH)) begin
            cons_next_s = best_len_d;
            out_data_d  = '0;
            out_data_d[WORD_SIZE] = 1'b1;
            out_data_d[WORD_SIZE-1 -: OFF_W] = OFF_W'(best_off_d - CNT_W'(1));
            out_data_d[WORD_SIZE-1-OFF_W -: LEN_W] =
               LEN_W'(best_len_d - LAC_W'(MIN_MATCH));
         end else begin
            cons_next_s = LAC_W'(1);
            out_data_d  = {1'b0, la_d[0]};
         end
         out_last_d = last_seen_d && (cons_next_s == la_cnt_d);
      end else begin
         cons_next_s = LAC_W'(1);
      end
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= FILL;
         la_cnt_q    <= '0;
         hist_cnt_q  <= '0;
         last_seen_q <= 1'b0;
         off_q       <= '0;
         best_len_q  <= '0;
         best_off_q  <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         for (int i = 0; i < LOOK_AHEAD_SIZE; i++) la_q[i] <= '0;
         for (int i = 0; i < WINDOW_SIZE; i++) hist_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         la_cnt_q    <= la_cnt_d;
         hist_cnt_q  <= hist_cnt_d;
         last_seen_q <= last_seen_d;
         off_q       <= off_d;
         best_len_q  <= best_len_d;
         best_off_q  <= best_off_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         la_q        <= la_d;
         hist_q      <= hist_d;
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign busy      = !((state_q == FILL) && (la_cnt_q == '0) && (hist_cnt_q == '0));

endmodule

// File: tb/tb_lzss_match_sequencer.sv
// Directed self-checking bench for lzss_match_sequencer.
module tb_lzss_match_sequencer;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_last = 1'b0;
   logic       in_ready;
   logic       out_valid;
   logic [8:0] out_data;
   logic       out_last;
   logic       out_ready = 1'b1;
   logic       busy;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   lzss_match_sequencer dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
      .busy(busy)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Cycle counter used for latency checks.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      in_last = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   // Present one word and hold it until it is accepted.
   task automatic feed_word(input logic [7:0] d, input logic l);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data = d;
      in_last = l;
      while (!in_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("feed_accept", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
   endtask

   task automatic feed_idle();
      @(negedge clk);
      in_valid = 1'b0;
      in_last = 1'b0;
   endtask

   task automatic feed_ab();
      for (int i = 0; i < 6; i++) feed_word((i % 2 == 1) ? 8'h42 : 8'h41, i == 5);
      feed_idle();
   endtask

   // Wait for a token (called between edges), check it, take the handshake.
   task automatic expect_tok(input string tag, input logic [8:0] d, input logic l, output int t);
      int n = 0;
      while (!out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_data"}, {23'd0, out_data}, {23'd0, d});
      chk({tag, "_last"}, {31'd0, out_last}, {31'd0, l});
      t = cyc;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic expect_ab(input string tag);
      int t;
      expect_tok({tag, "_t0"}, 9'h041, 1'b0, t);
      expect_tok({tag, "_t1"}, 9'h042, 1'b0, t);
      expect_tok({tag, "_t2"}, 9'h110, 1'b0, t);
      expect_tok({tag, "_t3"}, 9'h110, 1'b1, t);
   endtask

   initial begin
      int t;
      int tprev;
      int expi;

      // Reset with in_valid held high.
      rst = 1'b1;
      in_valid = 1'b1;
      in_data = 8'h55;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", {23'd0, out_data}, 32'd0);
      chk("rst_out_last", {31'd0, out_last}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;

      // A/B stream.
      do_reset();
      fork
         feed_ab();
         begin @(negedge clk); expect_ab("ab"); end
      join
      repeat (20) @(negedge clk);
      chk("ab_no_extra", {31'd0, out_valid}, 32'd0);
      chk("ab_idle_busy", {31'd0, busy}, 32'd0);

      // Single-word frame.
      do_reset();
      fork
         begin feed_word(8'h7F, 1'b1); feed_idle(); end
         begin @(negedge clk); expect_tok("single", 9'h07F, 1'b1, t); end
      join
      repeat (5) @(negedge clk);
      chk("single_busy", {31'd0, busy}, 32'd0);
      chk("single_no_extra", {31'd0, out_valid}, 32'd0);

      // 20 distinct words: literals in order, search time tracks history depth.
      do_reset();
      fork
         begin
            for (int i = 0; i < 20; i++) feed_word(8'(i), i == 19);
            feed_idle();
         end
         begin
            @(negedge clk);
            tprev = 0;
            for (int i = 0; i < 20; i++) begin
               expect_tok("seq", {1'b0, 8'(i)}, i == 19, t);
               if (i > 0) begin
                  expi = (i <= 16) ? i + 3 : 17;
                  chk("seq_interval", t - tprev, expi);
               end
               tprev = t;
            end
         end
      join
      repeat (5) @(negedge clk);
      chk("seq_no_extra", {31'd0, out_valid}, 32'd0);

      // Backpressure on the first token.
      do_reset();
      out_ready = 1'b0;
      fork
         feed_ab();
         begin
            int n = 0;
            @(negedge clk);
            while (!out_valid && n < 200) begin
               @(negedge clk);
               n++;
            end
            for (int j = 0; j < 10; j++) begin
               chk("bp_valid", {31'd0, out_valid}, 32'd1);
               chk("bp_data", {23'd0, out_data}, 32'h041);
               chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
               @(negedge clk);
            end
            out_ready = 1'b1;
            expect_ab("bp");
         end
      join
      repeat (10) @(negedge clk);
      chk("bp_no_extra", {31'd0, out_valid}, 32'd0);

      // Reset during the search for the third token.
      do_reset();
      fork
         feed_ab();
         begin
            @(negedge clk);
            expect_tok("rs_t0", 9'h041, 1'b0, t);
            expect_tok("rs_t1", 9'h042, 1'b0, t);
            repeat (2) @(negedge clk);
            chk("rs_search_busy", {31'd0, busy}, 32'd1);
            chk("rs_search_valid", {31'd0, out_valid}, 32'd0);
            chk("rs_search_in_ready", {31'd0, in_ready}, 32'd0);
            rst = 1'b1;
            #1;
            chk("rs_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rs_out_data", {23'd0, out_data}, 32'd0);
            chk("rs_busy", {31'd0, busy}, 32'd0);
            chk("rs_in_ready", {31'd0, in_ready}, 32'd0);
         end
      join
      repeat (5) @(negedge clk);
      chk("rs_held_valid", {31'd0, out_valid}, 32'd0);
      do_reset();
      fork
         feed_ab();
         begin @(negedge clk); expect_ab("rs_again"); end
      join

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/lzss_match_sequencer.md
Name: lzss_match_sequencer

Overview:
- Sequencing controller for the LZSS compression path. Buffers incoming words in a look-ahead buffer and keeps a sliding history window.
- Steps through window offsets one per cycle to find the longest match, then emits literal or reference tokens on a valid/ready stream.
- Sits between the raw byte source and the token packer/output FIFO.

Parameters:
- WORD_SIZE, 8: input word width; token width is WORD_SIZE+1.
- WINDOW_SIZE, 16: history depth in words (power of 2).
- LOOK_AHEAD_SIZE, 4: look-ahead buffer depth; also the maximum match length.
- MIN_MATCH, 2: shortest match emitted as a reference.
- Derived: OFF_W = clog2(WINDOW_SIZE); LEN_W = clog2(LOOK_AHEAD_SIZE-MIN_MATCH+1); OFF_W+LEN_W must be <= WORD_SIZE.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_data  in  WORD_SIZE  input word.
- in_last  in  1  marks the final word of a frame; qualified by in_valid&&in_ready.
- in_ready  out  1  sequencer accepts a word this cycle.
- out_valid  out  1  token valid.
- out_data  out  WORD_SIZE+1  token.
- out_last  out  1  final token of a frame.
- out_ready  in  1  downstream accepts the token.
- busy  out  1  high in any state other than FILL with an empty look-ahead and empty history.

Behaviour:
- While rst is high or on its assertion: all state cleared.
  - FSM=FILL, la_cnt=0, hist_cnt=0, last_seen=0.
  - out_valid=0, out_data=0, out_last=0, busy=0.
  - in_ready=0 while rst is high.
- Token format:
  - Literal = {1'b0, word}.
  - Reference = {1'b1, offset-1 (OFF_W), length-MIN_MATCH (LEN_W), zero pad}.
  - offset d is 1..hist_cnt; hist[0] is the most recently retired word.
- FILL state:
  - in_ready = (la_cnt<LOOK_AHEAD_SIZE) && !last_seen.
  - Each accepted word is appended at la[la_cnt]; in_last sets last_seen.
  - Leave when la_cnt==LOOK_AHEAD_SIZE, or when last_seen and la_cnt>0: go to SEARCH if hist_cnt>0, else EMIT.
  - The transition is evaluated on registered counts, so the cycle after the filling word is accepted.
- SEARCH state:
  - Takes exactly hist_cnt cycles; offset d = 1,2,...,hist_cnt, one per cycle; in_ready=0.
  - len(d) = the largest n such that la[k]==hist[d-1-k] for all k<n, with n <= min(d, la_cnt). Matches never overlap the look-ahead.
  - Replace best when len(d) > best_len (strict), so ties keep the smallest offset.
  - best_len and best_off are cleared on entry. After the last offset, go to EMIT.
- EMIT state:
  - out_valid=1 and out_data is registered and held stable until out_ready.
  - If best_len >= MIN_MATCH, emit a reference and consume best_len words; otherwise emit a literal of la[0] and consume 1.
  - out_last=1 when last_seen and the consume empties the look-ahead.
  - On handshake:
    - Consumed words shift into history in stream order; hist_cnt saturates at WINDOW_SIZE and the oldest entries drop.
    - The look-ahead shifts down by the consume count.
    - out_valid falls the next cycle.
  - Next state after handshake:
    - If out_last: clear history and look-ahead, last_seen=0, go to FILL (new frame independent).
    - Else if last_seen (remaining look-ahead >0): SEARCH, or EMIT if hist_cnt==0.
    - Else: FILL.
- Backpressure: out_ready low holds EMIT indefinitely with no state change; in_ready=0 throughout.
- A frame of a single word with in_last produces one literal with out_last=1.
- Async reset mid-SEARCH or mid-EMIT drops the pending token and all buffered data immediately; no token is emitted after the reset edge.

Test Plan:
- Reset with in_valid=1 held → in_ready=0, out_valid=0 during reset; in_ready=1 on the first cycle after release.
- Stream A,B,A,B,A,B (0x41,0x42,...), in_last on the 6th word, out_ready=1 → tokens 0x041, 0x042, 0x110, 0x110; out_last set only on the 4th.
- Single word 0x7F with in_last → one token 0x07F, out_last=1; history cleared; busy returns to 0.
- Stream 0x00..0x13 (20 distinct words, no repeats) → 20 literals in order; hist_cnt saturates at 16; SEARCH lasts exactly min(hist_cnt,16) cycles per token.
- out_ready low for 10 cycles during the first EMIT → out_data stable at 0x041; in_ready=0; no token lost or duplicated after release.
- Assert rst during SEARCH of the third token in the A/B stream → outputs zero immediately; after release the same stream reproduces 0x041, 0x042, 0x110, 0x110.
